// File: rtl/gray_pkg.sv
// Shared types and helpers for the binary-to-Gray sweep sequencer.
package gray_pkg;

  localparam int unsigned WIDTH_MAX = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_WRAP,
    ST_DONE
  } state_t;

  // Reference binary-to-Gray mapping at the widest supported code size.
  function automatic logic [WIDTH_MAX-1:0] bin2gray(input logic [WIDTH_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic is_one_hot(input logic [WIDTH_MAX-1:0] v);
    return (v != '0) && ((v & (v - WIDTH_MAX'(1))) == '0);
  endfunction

endpackage

// File: rtl/gray_step_checker.sv
// Combinational per-step check: reference mapping and single-bit-change rule.
module gray_step_checker
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  input  logic [WIDTH-1:0] gray,
  input  logic [WIDTH-1:0] prev_gray,
  input  logic             first,
  output logic             map_fail,
  output logic             adj_fail
);

  logic [WIDTH_MAX-1:0] ref_gray;

  assign ref_gray = bin2gray(WIDTH_MAX'(bin));
  assign map_fail = gray != WIDTH'(ref_gray);
  // The first code has no predecessor within the sweep.
  assign adj_fail = !first && !is_one_hot(WIDTH_MAX'(gray ^ prev_gray));

endmodule

// File: rtl/gray_sweep_ctrl.sv
// Sweeps every binary code through an external Gray converter and checks
// each returned code, plus the wrap from the last code back to code 0.
module gray_sweep_ctrl
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned STEP_WAIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] bin_out,
  input  logic [WIDTH-1:0] gray_in,
  output logic             code_valid,
  output logic [WIDTH-1:0] code_bin,
  output logic [WIDTH-1:0] code_gray,
  output logic             code_err,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH:0]   err_count
);

  localparam int unsigned      CNT_W       = 4;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = (STEP_WAIT > 0) ? CNT_W'(STEP_WAIT - 1) : '0;
  localparam logic             SKIP_SETTLE = (STEP_WAIT == 0);
  localparam logic [WIDTH-1:0] LAST_CODE   = '1;
  localparam logic [WIDTH:0]   COUNT_MAX   = '1;
  localparam logic [WIDTH:0]   COUNT_ONE   = (WIDTH+1)'(1);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [WIDTH-1:0] prev_gray, prev_gray_d;
  logic [WIDTH-1:0] gray_first, gray_first_d;
  logic [WIDTH-1:0] bin_out_d, code_bin_d, code_gray_d;
  logic             code_valid_d, code_err_d, busy_d, done_d, err_d;
  logic [WIDTH:0]   err_count_d;

  logic [WIDTH-1:0] chk_bin, chk_gray;
  logic             chk_first, map_fail, adj_fail;

  // WRAP reuses the checker: sampled code-0 gray against the last sampled gray.
  assign chk_bin   = (state == ST_WRAP) ? '0 : bin_out;
  assign chk_gray  = (state == ST_WRAP) ? gray_first : gray_in;
  assign chk_first = (state == ST_CHECK) && (bin_out == '0);

  gray_step_checker #(.WIDTH(WIDTH)) u_checker (
    .bin       (chk_bin),
    .gray      (chk_gray),
    .prev_gray (prev_gray),
    .first     (chk_first),
    .map_fail  (map_fail),
    .adj_fail  (adj_fail)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      prev_gray  <= '0;
      gray_first <= '0;
      bin_out    <= '0;
      code_valid <= 1'b0;
      code_bin   <= '0;
      code_gray  <= '0;
      code_err   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_count  <= '0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      prev_gray  <= prev_gray_d;
      gray_first <= gray_first_d;
      bin_out    <= bin_out_d;
      code_valid <= code_valid_d;
      code_bin   <= code_bin_d;
      code_gray  <= code_gray_d;
      code_err   <= code_err_d;
      busy       <= busy_d;
      done       <= done_d;
      err        <= err_d;
      err_count  <= err_count_d;
    end
  end

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    prev_gray_d  = prev_gray;
    gray_first_d = gray_first;
    bin_out_d    = bin_out;
    code_valid_d = 1'b0;
    code_bin_d   = code_bin;
    code_gray_d  = code_gray;
    code_err_d   = 1'b0;
    busy_d       = busy;
    done_d       = 1'b0;
    err_d        = err;
    err_count_d  = err_count;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          bin_out_d   = '0;
          err_d       = 1'b0;
          err_count_d = '0;
          busy_d      = 1'b1;
          cnt_d       = SETTLE_LOAD;
          state_d     = SKIP_SETTLE ? ST_CHECK : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt == '0) state_d = ST_CHECK;
        else           cnt_d   = cnt - CNT_W'(1);
      end
      ST_CHECK: begin
        code_valid_d = 1'b1;
        code_bin_d   = bin_out;
        code_gray_d  = gray_in;
        code_err_d   = map_fail || adj_fail;
        prev_gray_d  = gray_in;
        if (bin_out == '0) gray_first_d = gray_in;
        if (map_fail || adj_fail) begin
          err_d = 1'b1;
          if (err_count != COUNT_MAX) err_count_d = err_count + COUNT_ONE;
        end
        if (bin_out == LAST_CODE) begin
          state_d = ST_WRAP;
        end else begin
          bin_out_d = bin_out + WIDTH'(1);
          cnt_d     = SETTLE_LOAD;
          state_d   = SKIP_SETTLE ? ST_CHECK : ST_SETTLE;
        end
      end
      ST_WRAP: begin
        if (adj_fail) begin
          err_d = 1'b1;
          if (err_count != COUNT_MAX) err_count_d = err_count + COUNT_ONE;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_gray_sweep_ctrl.sv
// Directed bench for gray_sweep_ctrl: STEP_WAIT=1 and STEP_WAIT=0 instances
// driven by a bench-side converter with selectable faults.
module tb_gray_sweep_ctrl;

  localparam int unsigned W = 4;
  localparam logic [3:0] GRAY_TBL [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                          4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  logic clk = 1'b0;
  logic rst, start, start0;
  int   fault_mode;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [W-1:0] bin_out, gray_in, code_bin, code_gray;
  logic         code_valid, code_err, busy, done, err;
  logic [W:0]   err_count;

  logic [W-1:0] bin_out0, gray_in0, code_bin0, code_gray0;
  logic         code_valid0, code_err0, busy0, done0, err0;
  logic [W:0]   err_count0;

  always #5 clk = ~clk;

  // Converter model: 0 = correct, 1 = g0 stuck at 0, 2 = code 0 returns 0100.
  function automatic logic [W-1:0] conv(input logic [W-1:0] b, input int mode);
    logic [W-1:0] g;
    g = GRAY_TBL[b];
    if (mode == 1) g[0] = 1'b0;
    if (mode == 2 && b == '0) g = 4'b0100;
    return g;
  endfunction

  assign gray_in  = conv(bin_out, fault_mode);
  assign gray_in0 = conv(bin_out0, 0);

  gray_sweep_ctrl #(.WIDTH(W), .STEP_WAIT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .bin_out(bin_out), .gray_in(gray_in),
    .code_valid(code_valid), .code_bin(code_bin), .code_gray(code_gray), .code_err(code_err),
    .busy(busy), .done(done), .err(err), .err_count(err_count)
  );

  gray_sweep_ctrl #(.WIDTH(W), .STEP_WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .bin_out(bin_out0), .gray_in(gray_in0),
    .code_valid(code_valid0), .code_bin(code_bin0), .code_gray(code_gray0), .code_err(code_err0),
    .busy(busy0), .done(done0), .err(err0), .err_count(err_count0)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic run_sweep(input bit fast, input int mode, input bit pokes,
                           input int rst_at, input int ncyc);
    int           nv, ndone, done_at, exp_done, exp_cnt;
    logic [15:0]  exp_mask;
    logic [W-1:0] vb [16];
    logic [W-1:0] vg [16];
    logic         ve [16];
    logic [W-1:0] s_bin, s_cbin, s_cgray;
    logic         s_valid, s_cerr, s_busy, s_done, s_err;
    logic [W:0]   s_cnt;
    nv = 0; ndone = 0; done_at = 0;
    fault_mode = mode;
    @(negedge clk);
    if (fast) start0 = 1'b1; else start = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      start = 1'b0; start0 = 1'b0; rst = 1'b0;
      s_bin   = fast ? bin_out0    : bin_out;
      s_valid = fast ? code_valid0 : code_valid;
      s_cbin  = fast ? code_bin0   : code_bin;
      s_cgray = fast ? code_gray0  : code_gray;
      s_cerr  = fast ? code_err0   : code_err;
      s_busy  = fast ? busy0       : busy;
      s_done  = fast ? done0       : done;
      s_err   = fast ? err0        : err;
      s_cnt   = fast ? err_count0  : err_count;
      if (k == 1) begin
        check("busy_first", 32'(s_busy), 1);
        check("err_cleared", 32'(s_err), 0);
        check("cnt_cleared", 32'(s_cnt), 0);
      end
      if (fast && k <= 3) check($sformatf("fast_bin[%0d]", k), 32'(s_bin), k - 1);
      if (s_valid) begin
        if (nv < 16) begin
          vb[nv] = s_cbin; vg[nv] = s_cgray; ve[nv] = s_cerr;
        end
        nv++;
      end
      if (s_done) begin
        ndone++;
        done_at = k;
        check("busy_in_done", 32'(s_busy), 0);
      end
      if (rst_at != 0 && k == rst_at + 1) begin
        check("rst_bin", 32'(s_bin), 0);
        check("rst_outs", {s_valid, s_cbin, s_cgray, s_cerr, s_busy, s_done, s_err}, 0);
        check("rst_cnt", 32'(s_cnt), 0);
      end
      if (pokes && (k == 5 || s_done)) begin
        if (fast) start0 = 1'b1; else start = 1'b1;
      end
      if (rst_at != 0 && k == rst_at) rst = 1'b1;
    end
    if (rst_at != 0) begin
      check("rst_no_done", ndone, 0);
    end else begin
      exp_done = fast ? 18 : 34;
      case (mode)
        1:       begin exp_mask = 16'hEEEE; exp_cnt = 12; end
        2:       begin exp_mask = 16'h0003; exp_cnt = 3;  end
        default: begin exp_mask = 16'h0000; exp_cnt = 0;  end
      endcase
      check("done_pulses", ndone, 1);
      check("done_at", done_at, exp_done);
      check("valid_pulses", nv, 16);
      for (int i = 0; i < 16 && i < nv; i++) begin
        check($sformatf("code_bin[%0d]", i), 32'(vb[i]), i);
        check($sformatf("code_gray[%0d]", i), 32'(vg[i]), 32'(conv(W'(i), fast ? 0 : mode)));
        check($sformatf("code_err[%0d]", i), 32'(ve[i]), 32'(exp_mask[i]));
      end
      check("err", 32'(s_err), exp_cnt != 0 ? 1 : 0);
      check("err_count", 32'(s_cnt), exp_cnt);
      check("bin_hold", 32'(s_bin), 15);
      check("busy_after", 32'(s_busy), 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start0 = 1'b0; fault_mode = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_a", {code_valid, code_err, busy, done, err}, 0);
    check("reset_b", {bin_out, code_bin, code_gray, err_count}, 0);
    check("reset_fast", {bin_out0, code_valid0, code_bin0, code_gray0, code_err0,
                         busy0, done0, err0, err_count0}, 0);

    run_sweep(1'b0, 0, 1'b1, 0, 44);   // correct converter, ignored restarts
    run_sweep(1'b0, 1, 1'b0, 0, 44);   // g0 stuck at 0
    run_sweep(1'b0, 1, 1'b0, 0, 44);   // repeat: counters cleared, same result
    run_sweep(1'b0, 2, 1'b0, 0, 44);   // code 0 returns 0100
    run_sweep(1'b1, 0, 1'b0, 0, 24);   // STEP_WAIT=0 instance
    run_sweep(1'b0, 1, 1'b0, 10, 24);  // reset mid-sweep
    run_sweep(1'b0, 0, 1'b0, 0, 44);   // full sweep after reset abort

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
